// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and helper functions for the sequence stream
//                transmitter. Covers the sample-mode and FSM state enums, the
//                sample width, the per-mode next-value rule and the seed
//                zero-to-one mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        MODE_ASC  = 2'd0,
        MODE_DESC = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_ZIG  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // The receiver rejects a zero head sample, so a zero seed is promoted to 1.
    function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
        return (s == '0) ? DATA_W'(1) : s;
    endfunction

    // Increment on the nonzero ring 1..15.
    function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
        return (v == 4'd15) ? 4'd1 : v + 4'd1;
    endfunction

    // Decrement on the nonzero ring 1..15.
    function automatic logic [DATA_W-1:0] dec_wrap(input logic [DATA_W-1:0] v);
        return (v <= 4'd1) ? 4'd15 : v - 4'd1;
    endfunction

    // x^4+x^3+1, left shift; any nonzero state walks all 15 nonzero values.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

    // Next sample for the selected mode. Zigzag toggles between the seed and
    // its ring successor, so it needs the latched seed as a reference.
    function automatic logic [DATA_W-1:0] next_val(
        input mode_e             mode,
        input logic [DATA_W-1:0] v,
        input logic [DATA_W-1:0] seed
    );
        logic [DATA_W-1:0] nv;
        case (mode)
            MODE_ASC:  nv = inc_wrap(v);
            MODE_DESC: nv = dec_wrap(v);
            MODE_LFSR: nv = lfsr_next(v);
            default:   nv = (v == seed) ? inc_wrap(seed) : seed;
        endcase
        return nv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mono_window.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mono_window
//  Description : Three-deep window over the emitted samples of the current
//                run, counting strictly monotone triples with saturation.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                cnt_clr_i    - zero the triple counter
//                win_clr_i    - restart the run (window emptied; a sample
//                               pushed in the same cycle becomes its head)
//                push_i       - a sample is being emitted this cycle
//                data_i       - the emitted sample
//                count_o      - saturating monotone-triple count
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mono_window
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_clr_i,
    input  logic              win_clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] old_q;    // oldest retained sample (a)
    logic [DATA_W-1:0] new_q;    // newest retained sample (b)
    logic [1:0]        depth_q;  // number of valid retained samples, 0..2
    logic [CNT_W-1:0]  count_q;
    logic              triple_mono;

    // data_i is the third sample (c) of the triple formed on this push.
    always_comb begin
        triple_mono = (depth_q == 2'd2) &&
                      (((old_q < new_q) && (new_q < data_i)) ||
                       ((old_q > new_q) && (new_q > data_i)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            old_q   <= '0;
            new_q   <= '0;
            depth_q <= 2'd0;
            count_q <= '0;
        end else begin
            if (win_clr_i) begin
                old_q   <= '0;
                new_q   <= data_i;
                depth_q <= push_i ? 2'd1 : 2'd0;
            end else if (push_i) begin
                old_q <= new_q;
                new_q <= data_i;
                if (depth_q != 2'd2) begin
                    depth_q <= depth_q + 2'd1;
                end
            end

            if (cnt_clr_i) begin
                count_q <= '0;
            end else if (push_i && !win_clr_i && triple_mono && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_stream_tx
//  Description : Burst stimulus transmitter for the 4-bit sequence
//                monotonicity receiver. Emits cfg_len nonzero samples on
//                out_valid/out_data and tracks the expected number of
//                strictly monotone triples in parallel.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start             - burst request, honoured only when idle
//                cfg_mode/seed/len - sample rule, first sample, burst length
//                hold              - gap request while sending
//                out_valid/out_data- sample stream to the receiver
//                busy, done        - burst in progress / one-cycle end pulse
//                exp_count         - expected triple count, final at done
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_stream_tx
    import seq_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              hold,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  exp_count
);

    state_e            state_q,     state_d;
    mode_e             mode_q,      mode_d;
    logic [DATA_W-1:0] seed_q,      seed_d;
    logic [DATA_W-1:0] v_q,         v_d;
    logic [LEN_W-1:0]  rem_q,       rem_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              win_clr;
    logic              cnt_clr;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] start_seed;

    assign start_seed = seed_fix(cfg_seed);

    // rem_q counts samples still to be emitted. The first sample goes out on
    // the accepting edge so it is visible the cycle after start; SEND with
    // rem_q==0 is the cycle in which the last sample is on the outputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        v_d         = v_q;
        rem_d       = rem_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        win_clr     = 1'b0;
        cnt_clr     = 1'b0;
        push        = 1'b0;
        push_data   = v_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode_e'(cfg_mode);
                    seed_d  = start_seed;
                    cnt_clr = 1'b1;
                    win_clr = 1'b1;
                    busy_d  = 1'b1;
                    if (cfg_len == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        v_d     = start_seed;
                        rem_d   = '0;
                    end else begin
                        state_d     = ST_SEND;
                        push        = 1'b1;
                        push_data   = start_seed;
                        out_valid_d = 1'b1;
                        out_data_d  = start_seed;
                        v_d         = next_val(mode_e'(cfg_mode), start_seed, start_seed);
                        rem_d       = cfg_len - LEN_W'(1);
                    end
                end
            end

            ST_SEND: begin
                busy_d = 1'b1;
                if (rem_q == '0) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else if (hold) begin
                    // Gap on the wire ends the run at the receiver too.
                    win_clr = 1'b1;
                end else begin
                    push        = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = v_q;
                    v_d         = next_val(mode_q, v_q, seed_q);
                    rem_d       = rem_q - LEN_W'(1);
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ASC;
            seed_q      <= DATA_W'(1);
            v_q         <= DATA_W'(1);
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            v_q         <= v_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    seq_mono_window #(
        .CNT_W (CNT_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .cnt_clr_i (cnt_clr),
        .win_clr_i (win_clr),
        .push_i    (push),
        .data_i    (push_data),
        .count_o   (exp_count)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_stream_tx
//  Description : Self-checking bench for seq_stream_tx. A reference model
//                builds the expected per-cycle output stream from the sample
//                rules, the hold pattern and a run-based triple count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stream_tx;

    localparam int LEN_W   = 8;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int MAXC    = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       cfg_mode;
    logic [3:0]       cfg_seed;
    logic [LEN_W-1:0] cfg_len;
    logic             hold;
    logic             out_valid;
    logic [3:0]       out_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] exp_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected stream, indexed by cycles after the start cycle.
    int ev [MAXC];
    int ed [MAXC];
    int done_cyc;
    int exp_cnt;

    always #5 clk = ~clk;

    seq_stream_tx #(
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_mode  (cfg_mode),
        .cfg_seed  (cfg_seed),
        .cfg_len   (cfg_len),
        .hold      (hold),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .exp_count (exp_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Sample i of a burst, straight from the mode definitions.
    task automatic build_model(input int mode, input int seed, input int len,
                               input logic [MAXC-1:0] hmask);
        int samp [$];
        int win  [$];
        int s1;
        int v;
        int c;
        int idx;
        s1 = (seed == 0) ? 1 : seed;
        v  = s1;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: samp.push_back(((s1 - 1 + i) % 15) + 1);
                1: samp.push_back(((s1 - 1 - (i % 15) + 15) % 15) + 1);
                2: begin
                    samp.push_back(v);
                    v = ((v * 2) & 14) | (((v >> 3) ^ (v >> 2)) & 1);
                end
                default: samp.push_back((i % 2 == 0) ? s1 : ((s1 == 15) ? 1 : s1 + 1));
            endcase
        end
        for (int i = 0; i < MAXC; i++) begin
            ev[i] = 0;
            ed[i] = 0;
        end
        if (len == 0) begin
            done_cyc = 1;
        end else begin
            ev[1] = 1;
            ed[1] = samp[0];
            idx   = 1;
            c     = 2;
            while (idx < len) begin
                if (!hmask[c-1]) begin
                    ev[c] = 1;
                    ed[c] = samp[idx];
                    idx++;
                end
                c++;
            end
            done_cyc = c;
        end
        exp_cnt = 0;
        for (int cc = 1; cc <= done_cyc; cc++) begin
            if (ev[cc] != 0) begin
                win.push_back(ed[cc]);
                if (win.size() >= 3) begin
                    if ((win[$-2] < win[$-1] && win[$-1] < win[$]) ||
                        (win[$-2] > win[$-1] && win[$-1] > win[$])) begin
                        if (exp_cnt < CNT_MAX) exp_cnt++;
                    end
                end
            end else begin
                win.delete();
            end
        end
    endtask

    task automatic launch(input int mode, input int seed, input int len);
        cfg_mode = 2'(mode);
        cfg_seed = 4'(seed);
        cfg_len  = LEN_W'(len);
        hold     = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_burst(input string name, input int mode, input int seed, input int len,
                             input logic [MAXC-1:0] hmask, input int restart_at);
        build_model(mode, seed, len, hmask);
        launch(mode, seed, len);
        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            hold  = hmask[cyc];
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_seed = 4'($urandom_range(0, 15));
                cfg_len  = LEN_W'($urandom_range(1, 9));
            end
            check({name, ".valid"}, 32'(out_valid), ev[cyc]);
            check({name, ".data"},  32'(out_data),  ed[cyc]);
            check({name, ".busy"},  32'(busy),      (cyc <= done_cyc) ? 1 : 0);
            check({name, ".done"},  32'(done),      (cyc == done_cyc) ? 1 : 0);
            if (cyc >= done_cyc) begin
                check({name, ".count"}, 32'(exp_count), exp_cnt);
            end
            tick();
        end
        hold  = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_abort(input string name, input int mode, input int seed, input int len,
                             input int rst_cyc);
        build_model(mode, seed, len, '0);
        launch(mode, seed, len);
        for (int cyc = 1; cyc <= rst_cyc; cyc++) begin
            check({name, ".valid"}, 32'(out_valid), ev[cyc]);
            check({name, ".data"},  32'(out_data),  ed[cyc]);
            check({name, ".busy"},  32'(busy),      1);
            if (cyc == rst_cyc) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check({name, ".rst_valid"}, 32'(out_valid), 0);
        check({name, ".rst_data"},  32'(out_data),  0);
        check({name, ".rst_busy"},  32'(busy),      0);
        check({name, ".rst_done"},  32'(done),      0);
        check({name, ".rst_count"}, 32'(exp_count), 0);
        for (int k = 0; k < len + 3; k++) begin
            tick();
            check({name, ".post_done"},  32'(done),      0);
            check({name, ".post_valid"}, 32'(out_valid), 0);
        end
    endtask

    initial begin
        logic [MAXC-1:0] hm;

        rst      = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        cfg_mode = 2'd0;
        cfg_seed = 4'd0;
        cfg_len  = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset.valid", 32'(out_valid), 0);
        check("reset.data",  32'(out_data),  0);
        check("reset.busy",  32'(busy),      0);
        check("reset.done",  32'(done),      0);
        check("reset.count", 32'(exp_count), 0);

        // Ramp through the 15->1 wrap: 14,15,1,2,3, one triple.
        run_burst("asc_wrap", 0, 14, 5, '0, -1);
        check("asc_wrap.total", 32'(exp_count), 1);
        // Descending: 5,4,3,2, two triples.
        run_burst("desc", 1, 5, 4, '0, -1);
        check("desc.total", 32'(exp_count), 2);
        // LFSR from zero seed over a full period plus one.
        run_burst("lfsr16", 2, 0, 16, '0, -1);
        // Gap after two samples: 3,4,gap,5,6,7,8.
        hm = '0;
        hm[2] = 1'b1;
        run_burst("hold_gap", 0, 3, 6, hm, -1);
        check("hold_gap.total", 32'(exp_count), 2);
        // Boundary lengths.
        run_burst("len0", 0, 9, 0, '0, -1);
        run_burst("len1", 1, 9, 1, '0, -1);
        run_burst("len2", 0, 9, 2, '0, -1);
        run_burst("zig", 3, 7, 6, '0, -1);
        check("zig.total", 32'(exp_count), 0);
        run_burst("zig15", 3, 15, 7, '0, -1);
        // Start during SEND is ignored.
        run_burst("restart", 1, 12, 7, '0, 2);
        // Reset mid-burst, then a clean burst.
        run_abort("abort", 0, 2, 8, 3);
        run_burst("after_abort", 0, 2, 8, '0, -1);
        // Long ramp drives the counter into saturation.
        run_burst("saturate", 0, 1, 120, '0, -1);
        check("saturate.total", 32'(exp_count), CNT_MAX);

        for (int r = 0; r < 10; r++) begin
            hm = '0;
            for (int b = 2; b < MAXC; b++) begin
                hm[b] = ($urandom_range(0, 3) == 0);
            end
            run_burst("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 40)), hm, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
